// File: rtl/fixpoint_pkg.sv
// Shared types and the per-bit propagation rule
// for the token-chain fixpoint checker.
package fixpoint_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    CHECK,
    DONE
  } state_t;

  function automatic logic step_bit(
    input logic cur,
    input logic prev,
    input logic blk
  );
    return cur | (prev & ~blk);
  endfunction

endpackage

// File: rtl/fixpoint_step.sv
// One propagation step of a single token chain.
// Bit 0 is fed by the seed, bit i by bit i-1.
module fixpoint_step
  import fixpoint_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] blk,
  input  logic             seed,
  output logic [WIDTH-1:0] nxt,
  output logic             changed
);

  logic [WIDTH-1:0] prev;

  assign prev = {cur[WIDTH-2:0], seed};

  always_comb begin
    nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      nxt[i] = step_bit(cur[i], prev[i], blk[i]);
    end
  end

  assign changed = (nxt != cur);

endmodule

// File: rtl/fixpoint_checker.sv
// Iterates all token chains to a fixpoint (or a step
// budget) and reports convergence and tail agreement.
module fixpoint_checker
  import fixpoint_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int MAX_ITER = 2 * WIDTH,
  localparam int CW      = $clog2(MAX_ITER + 1),
  localparam int NB      = CHANNELS * WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NB-1:0] init_state,
  input  logic [NB-1:0] block_mask,
  input  logic [CHANNELS-1:0] seed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          fix_ok,
  output logic          tails_agree,
  output logic [CW-1:0] iter_count,
  output logic [NB-1:0] final_state
);

  state_t state, state_nxt;

  logic [NB-1:0]       cur_q;
  logic [NB-1:0]       blk_q;
  logic [CHANNELS-1:0] seed_q;
  logic [NB-1:0]       nxt_all;
  logic [CHANNELS-1:0] changed;
  logic [CHANNELS-1:0] tails;
  logic                any_change;
  logic                last_step;
  logic                agree;
  logic [CW-1:0]       cnt_inc;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    fixpoint_step #(
      .WIDTH(WIDTH)
    ) u_step (
      .cur    (cur_q[c*WIDTH +: WIDTH]),
      .blk    (blk_q[c*WIDTH +: WIDTH]),
      .seed   (seed_q[c]),
      .nxt    (nxt_all[c*WIDTH +: WIDTH]),
      .changed(changed[c])
    );
  end

  always_comb begin
    tails = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tails[c] = cur_q[c*WIDTH + WIDTH - 1];
    end
  end

  assign any_change = |changed;
  assign agree      = (&tails) | ~(|tails);
  assign last_step  = (iter_count == CW'(MAX_ITER - 1));
  assign cnt_inc    = (iter_count == CW'(MAX_ITER))
                    ? iter_count
                    : iter_count + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (in_valid) state_nxt = ITER;
      ITER:  if (!any_change || last_step)
               state_nxt = CHECK;
      CHECK: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q       <= '0;
      blk_q       <= '0;
      seed_q      <= '0;
      iter_count  <= '0;
      fix_ok      <= 1'b0;
      tails_agree <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          cur_q       <= init_state;
          blk_q       <= block_mask;
          seed_q      <= seed;
          iter_count  <= '0;
          fix_ok      <= 1'b0;
          tails_agree <= 1'b0;
        end
        ITER: begin
          iter_count <= cnt_inc;
          if (any_change) cur_q  <= nxt_all;
          else            fix_ok <= 1'b1;
        end
        CHECK: tails_agree <= fix_ok & agree;
        default: ;
      endcase
    end
  end

  assign final_state = cur_q;

endmodule

// File: tb/tb_fixpoint_checker.sv
// Directed bench for fixpoint_checker with a
// word-level reference model and a DONE-cycle checker.
module tb_fixpoint_checker;

  localparam int W  = 10;
  localparam int C  = 2;
  localparam int M  = 20;
  localparam int CW = $clog2(M + 1);
  localparam int C4 = $clog2(4 + 1);
  localparam int NB = C * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_valid4;
  logic          out_ready, out_ready4;
  logic [NB-1:0] init_state, block_mask;
  logic [C-1:0]  seed;

  logic          in_ready, out_valid, fix_ok, tails_agree;
  logic [CW-1:0] iter_count;
  logic [NB-1:0] final_state;

  logic          in_ready4, out_valid4, fix_ok4, tails4;
  logic [C4-1:0] iter4;
  logic [NB-1:0] final4;

  fixpoint_checker #(.WIDTH(W), .CHANNELS(C), .MAX_ITER(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .init_state(init_state), .block_mask(block_mask),
    .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready),
    .fix_ok(fix_ok), .tails_agree(tails_agree),
    .iter_count(iter_count), .final_state(final_state)
  );

  fixpoint_checker #(.WIDTH(W), .CHANNELS(C), .MAX_ITER(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .init_state(init_state), .block_mask(block_mask),
    .seed(seed),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .fix_ok(fix_ok4), .tails_agree(tails4),
    .iter_count(iter4), .final_state(final4)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // Reference: repeatedly apply the word-level step until
  // a step changes nothing or the budget is spent.
  task automatic model(input logic [NB-1:0] init,
                       input logic [NB-1:0] mask,
                       input logic [C-1:0] sd,
                       input int max,
                       output logic [NB-1:0] fin,
                       output int steps,
                       output bit ok,
                       output bit tl);
    logic [NB-1:0] n;
    logic [W-1:0]  cw, bw;
    logic [C-1:0]  tv;
    fin   = init;
    steps = 0;
    ok    = 0;
    while (steps < max) begin
      for (int c = 0; c < C; c++) begin
        cw = fin[c*W +: W];
        bw = mask[c*W +: W];
        n[c*W +: W] = cw | (((cw << 1) | W'(sd[c])) & ~bw);
      end
      steps++;
      if (n == fin) begin
        ok = 1;
        break;
      end
      fin = n;
    end
    for (int c = 0; c < C; c++) tv[c] = fin[c*W + W - 1];
    tl = ok && (tv == '0 || tv == '1);
  endtask

  logic [NB-1:0] exp_fin;
  int            exp_steps;
  bit            exp_ok, exp_tl;
  bit            armed = 0;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!armed) begin
        check("spurious_out_valid", out_valid, 1'b0);
      end else begin
        check("fix_ok", fix_ok, exp_ok);
        check("tails_agree", tails_agree, exp_tl);
        check("iter_count", iter_count, exp_steps);
        check("final_state", final_state, exp_fin);
        check("in_ready_in_done", in_ready, 1'b0);
      end
    end
  end

  int lat;

  task automatic start(input logic [NB-1:0] i,
                       input logic [NB-1:0] m,
                       input logic [C-1:0] s);
    @(negedge clk);
    init_state = i;
    block_mask = m;
    seed       = s;
    model(i, m, s, M, exp_fin, exp_steps, exp_ok, exp_tl);
    armed = 1;
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, exp_steps + 2);
  endtask

  task automatic release_done(input int hold);
    in_valid = 1'b1;
    repeat (hold) @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("back_to_idle", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b0;
    armed = 0;
  endtask

  logic [NB-1:0] f4;
  int            s4;
  bit            ok4, tl4;
  bit            seen;

  initial begin
    rst_n = 1'b0; in_valid = 0; in_valid4 = 0;
    out_ready = 0; out_ready4 = 0;
    init_state = '0; block_mask = '0; seed = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_iter", iter_count, 0);
    check("rst_final", final_state, 0);
    check("rst_flags", {fix_ok, tails_agree}, 2'b00);
    check("rst_dut4", {in_ready4, out_valid4, final4}, {2'b10, 20'h0});
    rst_n = 1'b1;

    // full propagation on both channels
    start(20'h0, 20'h0, 2'b11);
    check("t1_lat_lit", lat, 13);
    check("t1_final_lit", final_state, 20'hFFFFF);
    check("t1_iter_lit", iter_count, 11);
    check("t1_flags_lit", {fix_ok, tails_agree}, 2'b11);
    release_done(5);

    // channel 1 blocked at bit 5
    start(20'h0, 20'h08000, 2'b11);
    check("t2_final_lit", final_state, {10'h01F, 10'h3FF});
    check("t2_flags_lit", {fix_ok, tails_agree}, 2'b10);
    release_done(1);

    // nothing to do: first step is already stable
    start(20'h0, 20'h0, 2'b00);
    check("t3_iter_lit", iter_count, 1);
    release_done(2);

    // mixed init, masks and one seed
    start(20'h00201, 20'h00404, 2'b10);
    release_done(1);
    start(20'h80001, 20'h00010, 2'b01);
    release_done(1);

    // budget of 4 steps times out
    @(negedge clk);
    init_state = '0; block_mask = '0; seed = 2'b01;
    model(init_state, block_mask, seed, 4, f4, s4, ok4, tl4);
    check("t4_model_iter", s4, 4);
    in_valid4 = 1'b1;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid4) break;
    end
    check("t4_latency", lat, 6);
    check("t4_flags", {fix_ok4, tails4}, 2'b00);
    check("t4_iter", iter4, 4);
    check("t4_final_lit", final4, 20'h0000F);
    check("t4_final_model", final4, f4);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1 out_ready4 = 1'b0;
    check("t4_idle", in_ready4, 1'b1);

    // reset during the third step abandons the problem
    @(negedge clk);
    init_state = '0; block_mask = '0; seed = 2'b11;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", {in_ready, out_valid}, 2'b10);
    check("mid_rst_iter", iter_count, 0);
    check("mid_rst_final", final_state, 0);
    check("mid_rst_flags", {fix_ok, tails_agree}, 2'b00);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("mid_rst_no_verdict", seen, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
